// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm setpoint editor, time-match detector and ring/snooze sequencer
module alarm_controller #(
    parameter int TICK_DIV       = 50_000_000,
    parameter int SNOOZE_S       = 300,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       alarm_on,
    input  logic       alarm_set,
    input  logic       sel,
    input  logic       up,
    input  logic       down,
    input  logic       snooze,
    input  logic       dismiss,
    output logic [5:0] alarm_h,
    output logic [5:0] alarm_m,
    output logic       h_en,
    output logic       m_en,
    output logic       blink,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer
);
    localparam int DW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SNOOZE_S) + 1;
    localparam int RW = $clog2(RING_TIMEOUT_S) + 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_Q1    = DW'(TICK_DIV / 4);
    localparam logic [DW-1:0] DIV_HALF  = DW'(TICK_DIV / 2);
    localparam logic [DW-1:0] DIV_Q3    = DW'((3 * TICK_DIV) / 4);
    localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_S);
    localparam logic [SW-1:0] SNZ_ONE   = SW'(1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_S - 1);

    localparam int B_SEL  = 0;
    localparam int B_UP   = 1;
    localparam int B_DOWN = 2;
    localparam int B_SNZ  = 3;
    localparam int B_DIS  = 4;

    typedef enum logic [1:0] {IDLE, EDIT, RING, SNOOZE} state_t;

    state_t        state_q, state_d;
    logic          field_q, field_d;
    logic [5:0]    alarm_h_q, alarm_h_d;
    logic [5:0]    alarm_m_q, alarm_m_d;
    logic [DW-1:0] div_q, div_d;
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [6:0]    sync1_q, sync2_q;
    logic [4:0]    btn_prev_q;
    logic          match, match_q, match_dly_q;

    logic [4:0]    btn_edge;
    logic          set_lvl, on_lvl, tick, trigger;
    logic [5:0]    fld_val, fld_max, fld_new;

    always_comb begin
        btn_edge = sync2_q[4:0] & ~btn_prev_q;
        set_lvl  = sync2_q[5];
        on_lvl   = sync2_q[6];
        match    = (hours == alarm_h_q) && (minutes == alarm_m_q) && (seconds == 6'd0);
        trigger  = match_q & ~match_dly_q;
        tick     = (div_q == DIV_LAST);

        // Wrapping step of whichever field is being edited.
        fld_val = field_q ? alarm_m_q : alarm_h_q;
        fld_max = field_q ? 6'd59 : 6'd23;
        if (btn_edge[B_UP]) begin
            fld_new = (fld_val == fld_max) ? 6'd0 : fld_val + 6'd1;
        end else begin
            fld_new = (fld_val == 6'd0) ? fld_max : fld_val - 6'd1;
        end

        state_d    = state_q;
        field_d    = field_q;
        alarm_h_d  = alarm_h_q;
        alarm_m_d  = alarm_m_q;
        div_d      = tick ? '0 : div_q + 1'b1;
        snz_cnt_d  = snz_cnt_q;
        ring_cnt_d = ring_cnt_q;

        case (state_q)
            IDLE: begin
                if (set_lvl) begin
                    state_d = EDIT;
                    field_d = 1'b0;
                end else if (trigger && on_lvl) begin
                    state_d    = RING;
                    div_d      = '0;
                    ring_cnt_d = '0;
                end
            end
            EDIT: begin
                if (!set_lvl) begin
                    state_d = IDLE;
                end else begin
                    if (btn_edge[B_UP] ^ btn_edge[B_DOWN]) begin
                        if (field_q) alarm_m_d = fld_new;
                        else         alarm_h_d = fld_new;
                    end
                    if (btn_edge[B_SEL]) field_d = ~field_q;
                end
            end
            RING: begin
                if (set_lvl) begin
                    state_d = EDIT;
                    field_d = 1'b0;
                end else if (!on_lvl || btn_edge[B_DIS]) begin
                    state_d = IDLE;
                end else if (btn_edge[B_SNZ]) begin
                    state_d   = SNOOZE;
                    snz_cnt_d = SNZ_LOAD;
                    div_d     = '0;
                end else if (tick) begin
                    if (ring_cnt_q == RING_LAST) state_d = IDLE;
                    else                         ring_cnt_d = ring_cnt_q + 1'b1;
                end
            end
            SNOOZE: begin
                if (set_lvl) begin
                    state_d = EDIT;
                    field_d = 1'b0;
                end else if (!on_lvl || btn_edge[B_DIS]) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (snz_cnt_q <= SNZ_ONE) begin
                        state_d    = RING;
                        snz_cnt_d  = '0;
                        ring_cnt_d = '0;
                        div_d      = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            field_q     <= 1'b0;
            alarm_h_q   <= '0;
            alarm_m_q   <= '0;
            div_q       <= '0;
            snz_cnt_q   <= '0;
            ring_cnt_q  <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            btn_prev_q  <= '0;
            match_q     <= 1'b0;
            match_dly_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            alarm_h_q   <= alarm_h_d;
            alarm_m_q   <= alarm_m_d;
            div_q       <= div_d;
            snz_cnt_q   <= snz_cnt_d;
            ring_cnt_q  <= ring_cnt_d;
            sync1_q     <= {alarm_on, alarm_set, dismiss, snooze, down, up, sel};
            sync2_q     <= sync1_q;
            btn_prev_q  <= sync2_q[4:0];
            match_q     <= match;
            match_dly_q <= match_q;
        end
    end

    assign alarm_h  = alarm_h_q;
    assign alarm_m  = alarm_m_q;
    assign h_en     = (state_q == EDIT) && !field_q;
    assign m_en     = (state_q == EDIT) && field_q;
    assign blink    = (div_q < DIV_Q1) || ((div_q >= DIV_HALF) && (div_q < DIV_Q3));
    assign ringing  = (state_q == RING);
    assign snoozing = (state_q == SNOOZE);
    assign buzzer   = ringing & blink;

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Alarm sequencer for the 24-hour clock. It holds an alarm setpoint (hour, minute) edited from the push-buttons and watches the running time from `clock`. On a match it drives a ring/snooze/dismiss state machine and generates a 2 Hz-gated buzzer. It sits beside `clock_set` in the top level, and its `alarm_h`/`alarm_m`/field outputs feed the display path through `parser`/`seven_seg_driver`.

## Interface
- `TICK_DIV`, 50_000_000, clock cycles per second; must be a multiple of 4.
- `SNOOZE_S`, 300, snooze length in seconds (≥1).
- `RING_TIMEOUT_S`, 60, ring length in seconds before auto-dismiss (≥1).

- `clk_50MHz`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `hours`  in  6  current hour from `clock`, 0–23, same clock domain.
- `minutes`  in  6  current minute, 0–59.
- `seconds`  in  6  current second, 0–59.
- `alarm_on`  in  1  level; alarm armed.
- `alarm_set`  in  1  level; edit mode request.
- `sel`, `up`, `down`, `snooze`, `dismiss`  in  1 each  debounced buttons (level); only rising edges act.
- `alarm_h`  out  6  alarm hour setpoint, 0–23.
- `alarm_m`  out  6  alarm minute setpoint, 0–59.
- `h_en`, `m_en`  out  1 each  field under edit (one-hot in EDIT, both 0 elsewhere).
- `blink`  out  1  2 Hz square wave for display blanking.
- `ringing`  out  1  state is RING.
- `snoozing`  out  1  state is SNOOZE.
- `buzzer`  out  1  `ringing & blink`.

## Operation
- Button inputs pass through a 2-flop synchronizer, then a rising-edge detector (a one-cycle pulse per press). `alarm_set` and `alarm_on` are also 2-flop synchronized but used as levels.
- Tick divider `div` counts 0..TICK_DIV-1 and wraps.
  - A `tick` pulse fires on the wrap.
  - `blink` = 1 when `div` < TICK_DIV/4 or TICK_DIV/2 ≤ `div` < 3·TICK_DIV/4.
  - `div` is cleared on every entry to RING or SNOOZE.
- Match logic: `match` = (hours==alarm_h)&(minutes==alarm_m)&(seconds==0), registered into `match_q`; `match_d` is `match_q` delayed one cycle. A trigger is `match_q & !match_d`.
- FSM states and transitions (priority order within each state):
  - **IDLE**
    - `alarm_set`=1 → EDIT.
    - trigger & `alarm_on` → RING.
  - **EDIT**
    - `alarm_set`=0 → IDLE.
    - `sel` edge toggles field hour↔minute. Field is hour on entry.
    - `up` edge increments the selected field; `down` edge decrements it.
    - Hour wraps 23→0 and 0→23; minute wraps 59→0 and 0→59.
    - `up` and `down` edges in the same cycle → no change.
    - Triggers are ignored.
  - **RING**
    - `alarm_set` → EDIT.
    - `alarm_on`=0 → IDLE.
    - `dismiss` edge → IDLE.
    - `snooze` edge → SNOOZE (countdown loaded with SNOOZE_S).
    - RING_TIMEOUT_S ticks counted → IDLE.
  - **SNOOZE**
    - `alarm_set` → EDIT.
    - `alarm_on`=0 → IDLE.
    - `dismiss` edge → IDLE.
    - Each tick decrements the countdown; at 0 → RING (timeout counter restarted).
- Simultaneous `dismiss` and `snooze` edges → dismiss wins.
- Setpoints change only in EDIT and persist across all other states.
- Width rules: setpoints are 6-bit. Snooze and timeout counters are sized by `$clog2` of their parameter plus 1. No arithmetic overflow is permitted.

## Timing
- Reset (async assert, sync release): state IDLE, `alarm_h`=0, `alarm_m`=0, `div`=0, all counters 0, synchronizers and edge detectors 0, `match_q`=`match_d`=0.
- Reset values of all outputs: `h_en`=`m_en`=`ringing`=`snoozing`=`buzzer`=0; `blink`=1 (div=0).
- Button latency: a raw rising edge at cycle N gives an edge pulse at cycle N+2, and the resulting state or setpoint change is visible at N+3.
- Match latency: time inputs first matching at cycle N → `ringing`=1 at N+2.
- Timer durations are exact, because `div` is cleared on entry:
  - RING auto-dismiss occurs RING_TIMEOUT_S·TICK_DIV cycles after entry.
  - SNOOZE returns to RING SNOOZE_S·TICK_DIV cycles after entry.
- A sustained match (the whole second 00) produces exactly one trigger.
  - Dismissing during that second does not retrigger.
  - Leaving EDIT during a match does not trigger.
- Reset mid-RING/SNOOZE: outputs clear immediately (asynchronous) and the setpoint returns to 00:00.

## Test plan
Bench parameters: TICK_DIV=8, SNOOZE_S=3, RING_TIMEOUT_S=4.
- Reset, then hold `alarm_set`=1 and give `up` ×2, `sel`, `down` ×1 → `alarm_h`=2, `alarm_m`=59. `h_en`/`m_en` track the field. Release `alarm_set` → IDLE, both 0.
- Setpoint 07:30, `alarm_on`=1; drive time 07:29:59 → 07:30:00 → `ringing` rises 2 cycles later. `buzzer` pattern is 2 high / 2 low cycles. `ringing` falls after 32 cycles.
- Ringing; `snooze` press → `snoozing`=1 for 24 cycles, then `ringing`=1. `dismiss` press → IDLE 3 cycles after the press. Holding time at 07:30:00 gives no retrigger.
- Ringing; `snooze` and `dismiss` rise in the same cycle → IDLE, `snoozing` never asserts.
- In EDIT with hour=0: `down` → 23; `up` → 0; `up`+`down` together → unchanged. Minute 59 + `up` → 0.
- Assert `reset`=0 mid-SNOOZE → all outputs 0 (`blink`=1) without a clock edge. After release, `alarm_h`=`alarm_m`=0 and the state is IDLE.
